// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the single-ported unified memory.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM,
    RESP
  } stateT;

  stateT state;
  stateT stateNext;

  logic grantDm;
  logic grantIf;
  logic forceIf;
  logic ownerDm;
  logic hiHalf;

  logic              memWeQ;
  logic [ADDR_W-1:0] memAddrQ;
  logic [DATA_W-1:0] memWdataQ;
  logic [31:0]       ifRdataQ;
  logic [DATA_W-1:0] dmRdataQ;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starveCnt;

  assign forceIf = if_req && (starveCnt == LIM);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      starveCnt <= '0;
    end else if (grantIf) begin
      starveCnt <= '0;
    end else if (grantDm) begin
      if (!if_req)
        starveCnt <= '0;
      else if (starveCnt != LIM)
        starveCnt <= starveCnt + CW'(1);
    end
  end
`else
  assign forceIf = 1'b0;
`endif

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)
      state <= IDLE;
    else
      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    grantDm   = 1'b0;
    grantIf   = 1'b0;
    unique case (state)
      IDLE: begin
        grantDm = dm_req && !forceIf;
        grantIf = if_req && !grantDm;
        if (grantDm)
          stateNext = BUSY_DM;
        else if (grantIf)
          stateNext = BUSY_IF;
      end
      BUSY_IF: begin
        if (mem_ready)
          stateNext = RESP;
      end
      BUSY_DM: begin
        if (mem_ready)
          stateNext = RESP;
      end
      RESP: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      memWeQ    <= 1'b0;
      memAddrQ  <= '0;
      memWdataQ <= '0;
      ifRdataQ  <= '0;
      dmRdataQ  <= '0;
      ownerDm   <= 1'b0;
      hiHalf    <= 1'b0;
    end else begin
      if (grantDm) begin
        memWeQ    <= dm_we;
        memAddrQ  <= dm_addr;
        memWdataQ <= dm_wdata;
      end else if (grantIf) begin
        memWeQ    <= 1'b0;
        memAddrQ  <= if_addr;
        memWdataQ <= '0;
        hiHalf    <= if_addr[2];
      end
      // Results land in per-requester registers so each side keeps its own
      if (mem_ready && state == BUSY_IF) begin
        ownerDm  <= 1'b0;
        ifRdataQ <= hiHalf ? mem_rdata[63:32]
                           : mem_rdata[31:0];
      end
      if (mem_ready && state == BUSY_DM) begin
        ownerDm <= 1'b1;
        if (!memWeQ)
          dmRdataQ <= mem_rdata;
      end
    end
  end

  assign mem_req   = (state == BUSY_IF) ||
                     (state == BUSY_DM);
  assign mem_we    = memWeQ;
  assign mem_addr  = memAddrQ;
  assign mem_wdata = memWdataQ;
  assign busy      = (state != IDLE);
  assign if_ack    = (state == RESP) && !ownerDm;
  assign dm_ack    = (state == RESP) && ownerDm;
  assign if_rdata  = ifRdataQ;
  assign dm_rdata  = dmRdataQ;
  assign if_stall  = if_req && !if_ack;
  assign dm_stall  = dm_req && !dm_ack;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one single-ported unified memory between the instruction-fetch stage and the data-memory (MEM) stage of the five-stage ARMLEG pipeline. It registers each granted request onto the memory port and waits for the memory's ready handshake. It returns read data with a one-cycle acknowledge and drives stall outputs into the PC-write and IF/ID-write hold logic.

## Interface
Parameters:
- ADDR_W, 64, address width of both requesters and the memory port
- DATA_W, 64, memory data width
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch is pending (used only with ARB_STARVE_GUARD_EN)

Ports:
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  ADDR_W  fetch byte address
- if_ack  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  32  fetched instruction word
- dm_req  in  1  data request, level, held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data byte address
- dm_wdata  in  DATA_W  store data
- dm_ack  out  1  one-cycle pulse; access complete, dm_rdata valid for loads
- dm_rdata  out  DATA_W  load data
- mem_req  out  1  memory access request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completes the current access this cycle
- if_stall  out  1  if_req & ~if_ack, combinational
- dm_stall  out  1  dm_req & ~dm_ack, combinational
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
- IDLE:
  - dm_req=1 → BUSY_DM, except when the starve guard forces fetch.
  - Otherwise if_req=1 → BUSY_IF.
  - Otherwise stay in IDLE.
- On grant:
  - mem_addr, mem_we and mem_wdata are registered from the winner.
  - Fetch grants force mem_we=0 and mem_wdata=0.
  - Requester inputs are ignored until its ack.
- BUSY_x:
  - mem_req=1.
  - mem_ready=1 → capture mem_rdata, go to RESP, record owner.
  - mem_ready=0 → hold all port outputs and stay in BUSY_x.
- RESP:
  - mem_req=0.
  - Owner's ack=1 for exactly this cycle.
  - Always → IDLE (one turnaround cycle between accesses).
- if_rdata = captured [31:0] when the latched if_addr[2]=0, else [63:32].
- dm_rdata = full captured word; holds its last value after a store.
- Requester rule: it may change req, addr and data only after sampling its ack. IDLE arbitrates at the edge following RESP.
- mem_ready while in IDLE or RESP is ignored.
- Simultaneous if_req and dm_req: the data request wins by default. This stops a load/store from deadlocking behind a fetch that the hazard unit is itself stalling.

## Timing
- Reset (RESET=0, asynchronous):
  - State → IDLE, starve counter → 0.
  - mem_req, mem_we, if_ack, dm_ack, busy → 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata → 0.
- Reset mid-access: the in-flight transaction is abandoned and mem_req drops immediately. The memory must tolerate this.
- Latency:
  - req sampled high at edge 0 → mem_req high in cycle 1.
  - If mem_ready=1 in cycle 1, ack is high in cycle 2. Minimum 2 cycles from the grant edge to ack.
  - Each wait-state cycle adds 1 cycle.
- Back-to-back throughput: one access per 3 cycles with zero-wait memory (BUSY, RESP, IDLE).
- if_stall and dm_stall are combinational from req and ack. They are never high during the ack cycle.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A saturating counter (width clog2(STARVE_LIMIT+1)) increments on each data grant made while if_req=1.
  - It clears on any fetch grant, or on a data grant with if_req=0.
  - When the counter equals STARVE_LIMIT and if_req=1, IDLE grants fetch even if dm_req=1.
- Undefined: the counter is not built. The data requester has strict priority and fetch can starve indefinitely.

## Test plan
- Reset: hold RESET=0, toggle CLOCK with both reqs high → mem_req=0, acks=0, busy=0. Release → grant at the first edge.
- Single fetch: if_addr=0x4, mem_rdata=0x11223344_AABBCCDD, zero wait → mem_req in cycle 1, if_ack in cycle 2, if_rdata=0x11223344.
- Store with 3 wait states: dm_we=1, dm_addr=0x40, dm_wdata=0xDEAD → mem_we=1 and mem_addr=0x40 held for 4 cycles, dm_ack 1 cycle after mem_ready. dm_stall is high every cycle before the ack.
- Simultaneous requests, guard undefined: both reqs held continuously → six consecutive dm_acks, no if_ack, if_stall remains 1.
- Guard defined, STARVE_LIMIT=4: both reqs held continuously → grant order DM, DM, DM, DM, IF, DM, … with the counter back at 0 after the IF grant.
- Reset mid-access: assert RESET=0 during BUSY_DM with mem_ready=0 → mem_req falls without waiting for CLOCK, no dm_ack. After release, a re-presented dm_req completes normally.
